// File: rtl/uart_pkg.sv
// Shared UART types: receiver state encoding and parity sense constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4,
        ST_BRK   = 3'd5
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with exact occupancy count and registered flags.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot a same-cycle push needs when full; an empty FIFO ignores pops.
    always_comb begin
        do_pop  = pop & ~empty_q;
        do_push = push & (~full_q | do_pop);
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Storage, pointers and flags; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr_q] <= wdata;
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver: synchroniser, mid-bit sampling FSM, parity/stop checks,
// sticky error flags and a show-ahead receive FIFO.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 2604,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_EN   = 0,
    parameter int unsigned PARITY_ODD  = 0,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         RX,
    input  logic                         rd_en,
    input  logic                         clr_err,
    output logic [DATA_BITS-1:0]         rx_data,
    output logic                         rdy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt,
    output logic                         parity_err,
    output logic                         frame_err,
    output logic                         overrun
);

    localparam int unsigned BAUD_W = $clog2(CLK_PER_BIT + 1);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
    // Counter expires at zero, so load one less than the wanted interval.
    localparam logic [BAUD_W-1:0] BAUD_HALF_LD = BAUD_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_FULL_LD = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT     = BIT_W'(DATA_BITS - 1);
    localparam logic              PAR_SEL      = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    rx_state_t             state_q;
    rx_state_t             state_d;
    logic                  rx_s1_q;
    logic                  rx_sync_q;
    logic [BAUD_W-1:0]     baud_cnt_q;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic [DATA_BITS-1:0]  shift_q;
    logic                  par_bad_q;
    logic                  push_q;
    logic                  tick;
    logic                  ld_half;
    logic                  ld_full;
    logic                  bit_clr;
    logic                  shift_en;
    logic                  par_en;
    logic                  push_d;
    logic                  frame_set;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  overflow;

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_s1_q   <= RX;
            rx_sync_q <= rx_s1_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes; every sample happens when the baud counter expires.
    always_comb begin
        state_d   = state_q;
        ld_half   = 1'b0;
        ld_full   = 1'b0;
        bit_clr   = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        push_d    = 1'b0;
        frame_set = 1'b0;
        tick      = (baud_cnt_q == '0);
        case (state_q)
            ST_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = ST_START;
                    ld_half = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_sync_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        ld_full = 1'b1;
                        bit_clr = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    ld_full  = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? ST_PAR : ST_STOP;
                    end
                end
            end
            ST_PAR: begin
                if (tick) begin
                    par_en  = 1'b1;
                    ld_full = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rx_sync_q) begin
                        push_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = ST_BRK;
                    end
                end
            end
            ST_BRK: begin
                if (rx_sync_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Baud/bit counters, shift register and parity verdict; counters only load or count down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            push_q     <= 1'b0;
        end else begin
            if (ld_half) begin
                baud_cnt_q <= BAUD_HALF_LD;
            end else if (ld_full) begin
                baud_cnt_q <= BAUD_FULL_LD;
            end else if (baud_cnt_q != '0) begin
                baud_cnt_q <= baud_cnt_q - BAUD_W'(1);
            end
            if (bit_clr) begin
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
            if (shift_en) begin
                shift_q <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
            end
            if (par_en) begin
                par_bad_q <= ((^shift_q) ^ rx_sync_q) != PAR_SEL;
            end
            push_q <= push_d;
        end
    end

    assign overflow = push_q & fifo_full & ~(rd_en & ~fifo_empty);

    // Sticky error flags; a set in the same cycle wins over clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (push_q && par_bad_q) begin
                parity_err <= 1'b1;
            end else if (clr_err) begin
                parity_err <= 1'b0;
            end
            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (overflow) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .pop   (rd_en),
        .wdata (shift_q),
        .rdata (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .cnt   (fifo_cnt)
    );

    assign rdy = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: one 8N1 instance and one 8E1 instance.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx0, rx1;
    logic       rd_en0, rd_en1;
    logic       clr_err0, clr_err1;
    logic [7:0] rx_data0, rx_data1;
    logic       rdy0, rdy1;
    logic [2:0] cnt0, cnt1;
    logic       perr0, perr1;
    logic       ferr0, ferr1;
    logic       ovr0, ovr1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .RX(rx0), .rd_en(rd_en0), .clr_err(clr_err0),
        .rx_data(rx_data0), .rdy(rdy0), .fifo_cnt(cnt0),
        .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0)
    );

    uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut_p (
        .clk(clk), .rst(rst), .RX(rx1), .rd_en(rd_en1), .clr_err(clr_err1),
        .rx_data(rx_data1), .rdy(rdy1), .fifo_cnt(cnt1),
        .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1)
    );

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx1 = v;
        else     rx0 = v;
    endtask

    task automatic bit_time(input bit sel, input logic v);
        set_line(sel, v);
        repeat (CPB) @(negedge clk);
    endtask

    // One frame starting on a negedge; pop_at >= 0 pulses rd_en0 at that clock of the stop bit.
    task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                              input logic par, input logic stop, input int pop_at);
        bit_time(sel, 1'b0);
        for (int i = 0; i < 8; i++) bit_time(sel, d[i]);
        if (use_par) bit_time(sel, par);
        set_line(sel, stop);
        for (int c = 0; c < CPB; c++) begin
            if (pop_at >= 0) rd_en0 = (c == pop_at);
            @(negedge clk);
        end
        rd_en0 = 1'b0;
    endtask

    task automatic pop0();
        rd_en0 = 1'b1;
        @(negedge clk);
        rd_en0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear0();
        clr_err0 = 1'b1;
        @(negedge clk);
        clr_err0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy0, cnt0, perr0, ferr0, ovr0, rx_data0} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b cnt=%0d perr=%b ferr=%b ovr=%b data=%h, want all 0",
                     rdy0, cnt0, perr0, ferr0, ovr0, rx_data0);
        end
        checks++;
        if ({rdy1, cnt1, perr1, ferr1, ovr1} !== 6'h0) begin
            errors++;
            $display("FAIL reset_outputs_par: rdy=%b cnt=%0d perr=%b, want 0", rdy1, cnt1, perr1);
        end
    endtask

    task automatic test_single();
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, -1);
        checks++;
        if (rdy0 !== 1'b1 || rx_data0 !== 8'hA5 || cnt0 !== 3'd1) begin
            errors++;
            $display("FAIL single_rx: rdy=%b data=%h cnt=%0d, want 1 a5 1", rdy0, rx_data0, cnt0);
        end
        checks++;
        if ({perr0, ferr0, ovr0} !== 3'b000) begin
            errors++;
            $display("FAIL single_flags: p=%b f=%b o=%b, want 000", perr0, ferr0, ovr0);
        end
        pop0();
        checks++;
        if (rdy0 !== 1'b0 || cnt0 !== 3'd0) begin
            errors++;
            $display("FAIL single_pop: rdy=%b cnt=%0d, want 0 0", rdy0, cnt0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 0, 1'b0, 1'b1, -1);
        checks++;
        if (cnt0 !== 3'd4 || ovr0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_fill: cnt=%0d ovr=%b, want 4 0", cnt0, ovr0);
        end
        send_frame(0, 8'h05, 0, 1'b0, 1'b1, -1);
        checks++;
        if (cnt0 !== 3'd4 || ovr0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_overrun: cnt=%0d ovr=%b, want 4 1", cnt0, ovr0);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (rx_data0 !== 8'(i) || rdy0 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_order%0d: data=%h rdy=%b, want %h 1", i, rx_data0, rdy0, 8'(i));
            end
            pop0();
        end
        checks++;
        if (cnt0 !== 3'd0 || rdy0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: cnt=%0d rdy=%b, want 0 0", cnt0, rdy0);
        end
        clear0();
        checks++;
        if (ovr0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_clr: ovr=%b, want 0", ovr0);
        end
    endtask

    task automatic test_parity();
        send_frame(1, 8'h03, 1, 1'b1, 1'b1, -1);
        checks++;
        if (rdy1 !== 1'b1 || rx_data1 !== 8'h03 || perr1 !== 1'b1 || ferr1 !== 1'b0) begin
            errors++;
            $display("FAIL parity_bad: rdy=%b data=%h perr=%b ferr=%b, want 1 03 1 0",
                     rdy1, rx_data1, perr1, ferr1);
        end
        clr_err1 = 1'b1;
        @(negedge clk);
        clr_err1 = 1'b0;
        @(negedge clk);
        checks++;
        if (perr1 !== 1'b0) begin
            errors++;
            $display("FAIL parity_clr: perr=%b, want 0", perr1);
        end
        send_frame(1, 8'h03, 1, 1'b0, 1'b1, -1);
        checks++;
        if (perr1 !== 1'b0 || cnt1 !== 3'd2) begin
            errors++;
            $display("FAIL parity_good: perr=%b cnt=%0d, want 0 2", perr1, cnt1);
        end
    endtask

    task automatic test_glitch();
        rx0 = 1'b0;
        repeat (4) @(negedge clk);
        rx0 = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if ({rdy0, cnt0, perr0, ferr0, ovr0} !== 7'h0) begin
            errors++;
            $display("FAIL glitch: rdy=%b cnt=%0d p=%b f=%b o=%b, want all 0", rdy0, cnt0, perr0, ferr0, ovr0);
        end
    endtask

    task automatic test_frame_err();
        send_frame(0, 8'h55, 0, 1'b0, 1'b0, -1);
        repeat (5 * CPB) @(negedge clk);
        rx0 = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (ferr0 !== 1'b1 || cnt0 !== 3'd0 || rdy0 !== 1'b0) begin
            errors++;
            $display("FAIL frame_err: ferr=%b cnt=%0d rdy=%b, want 1 0 0", ferr0, cnt0, rdy0);
        end
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1, -1);
        checks++;
        if (rx_data0 !== 8'h3C || cnt0 !== 3'd1 || ferr0 !== 1'b1) begin
            errors++;
            $display("FAIL frame_recover: data=%h cnt=%0d ferr=%b, want 3c 1 1", rx_data0, cnt0, ferr0);
        end
        pop0();
        clear0();
        checks++;
        if (ferr0 !== 1'b0 || cnt0 !== 3'd0) begin
            errors++;
            $display("FAIL frame_clr: ferr=%b cnt=%0d, want 0 0", ferr0, cnt0);
        end
    endtask

    task automatic test_full_pop_push();
        for (int i = 0; i < 4; i++) send_frame(0, 8'h10 + 8'(i), 0, 1'b0, 1'b1, -1);
        // The FIFO write lands on the posedge 11.5 clocks into the stop bit.
        send_frame(0, 8'h14, 0, 1'b0, 1'b1, 11);
        checks++;
        if (cnt0 !== 3'd4 || ovr0 !== 1'b0 || rx_data0 !== 8'h11) begin
            errors++;
            $display("FAIL full_pushpop: cnt=%0d ovr=%b head=%h, want 4 0 11", cnt0, ovr0, rx_data0);
        end
        send_frame(0, 8'h15, 0, 1'b0, 1'b1, -1);
        checks++;
        if (ovr0 !== 1'b1 || cnt0 !== 3'd4) begin
            errors++;
            $display("FAIL full_drop: ovr=%b cnt=%0d, want 1 4", ovr0, cnt0);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (rx_data0 !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL full_order%0d: data=%h, want %h", i, rx_data0, 8'h10 + 8'(i));
            end
            pop0();
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(0, 8'h20, 0, 1'b0, 1'b1, -1);
        bit_time(0, 1'b0);
        bit_time(0, 1'b1);
        bit_time(0, 1'b0);
        rst = 1'b1;
        rx0 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rdy0, cnt0, perr0, ferr0, ovr0, rx_data0} !== 14'h0) begin
            errors++;
            $display("FAIL midframe_reset: rdy=%b cnt=%0d ovr=%b data=%h, want 0", rdy0, cnt0, ovr0, rx_data0);
        end
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (rdy0 !== 1'b0 || ferr0 !== 1'b0) begin
            errors++;
            $display("FAIL midframe_idle: rdy=%b ferr=%b, want 0 0", rdy0, ferr0);
        end
        send_frame(0, 8'h7E, 0, 1'b0, 1'b1, -1);
        checks++;
        if (rx_data0 !== 8'h7E || cnt0 !== 3'd1) begin
            errors++;
            $display("FAIL midframe_next: data=%h cnt=%0d, want 7e 1", rx_data0, cnt0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx0      = 1'b1;
        rx1      = 1'b1;
        rd_en0   = 1'b0;
        rd_en1   = 1'b0;
        clr_err0 = 1'b0;
        clr_err1 = 1'b0;
        @(negedge clk);
        test_reset();
        repeat (4) @(negedge clk);
        test_single();
        test_back_to_back();
        test_parity();
        test_glitch();
        test_frame_err();
        test_full_pop_push();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
